// File: rtl/core_seq_ctrl_pkg.sv
// rtl/core_seq_ctrl_pkg.sv - shared widths, instruction codes, sequencer states and decode helper
//
// Contents:
//   INST_NUM_WIDTH / INST_TYPE_WIDTH  widths of the decoded instruction code and format
//   INST_*                            decoded instruction codes understood by the sequencer
//   TYPE_*                            instruction formats R/I/S/B/U/J
//   seq_state_e                       sequencer state encoding
//   inst_cls_e / classify()           what the sequencer does with an instruction code after EXEC
package core_seq_ctrl_pkg;

    localparam int INST_NUM_WIDTH  = 6;
    localparam int INST_TYPE_WIDTH = 3;

    localparam logic [INST_NUM_WIDTH-1:0] INST_ADD    = 6'd1;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SUB    = 6'd2;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI   = 6'd3;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LUI    = 6'd4;
    localparam logic [INST_NUM_WIDTH-1:0] INST_AUIPC  = 6'd5;
    localparam logic [INST_NUM_WIDTH-1:0] INST_JAL    = 6'd6;
    localparam logic [INST_NUM_WIDTH-1:0] INST_JALR   = 6'd7;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ    = 6'd8;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BNE    = 6'd9;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LW     = 6'd10;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SH     = 6'd11;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SW     = 6'd12;
    localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 6'd13;

    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_R = 3'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_I = 3'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_S = 3'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_B = 3'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_U = 3'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_J = 3'd5;

    // Nine states do not fit in three bits, so the encoding is four bits wide.
    typedef enum logic [3:0] {
        SEQ_IDLE     = 4'd0,
        SEQ_IF_REQ   = 4'd1,
        SEQ_IF_WAIT  = 4'd2,
        SEQ_EXEC     = 4'd3,
        SEQ_MEM_REQ  = 4'd4,
        SEQ_MEM_WAIT = 4'd5,
        SEQ_WB       = 4'd6,
        SEQ_HALT     = 4'd7,
        SEQ_ERR      = 4'd8
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STORE = 3'd2,
        CLS_HALT  = 3'd3,
        CLS_BAD   = 3'd4
    } inst_cls_e;

    function automatic inst_cls_e classify(input logic [INST_NUM_WIDTH-1:0] num);
        case (num)
            INST_ADD, INST_SUB, INST_ADDI, INST_LUI, INST_AUIPC,
            INST_JAL, INST_JALR, INST_BEQ, INST_BNE: return CLS_ALU;
            INST_LW:                                 return CLS_LOAD;
            INST_SH, INST_SW:                        return CLS_STORE;
            INST_EBREAK:                             return CLS_HALT;
            default:                                 return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/core_seq_ctrl_wait_cnt.sv
// rtl/core_seq_ctrl_wait_cnt.sv - watchdog counter for the sequencer memory-wait states
//
// Ports:
//   clk     in   core clock
//   rst     in   synchronous active-high reset, clears the count
//   clr     in   clears the count (state change)
//   inc     in   count this cycle (sequencer is in a memory-wait state)
//   expire  out  this is the last allowed wait cycle; TIMEOUT_CYCLES=0 never expires
module seq_wait_cnt
    import core_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // Holding at LAST on expiry keeps the count in range; the sequencer leaves the
    // wait state on that same edge, so the hold is never observed in practice.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES > 0) && inc && (cnt == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle fetch/execute/memory/writeback sequencer for the NPC core
//
// Ports:
//   clk, rst                          core clock, synchronous active-high reset
//   inst_num, inst_type               decoded instruction code and format (stable EXEC..WB)
//   ifu_req_valid/ready, ifu_rsp_valid  instruction fetch handshake
//   inst_latch_en                     pulse: IFU latches the instruction word
//   lsu_req_valid/ready, lsu_we, lsu_rsp_valid  data memory handshake
//   mem_r_latch_en                    pulse: latch load data
//   gpr_w_en, pc_w_en                 write-back strobes (WB only)
//   instret                           retired-instruction counter
//   halt, err                         core stopped / stopped on error
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int INSTRET_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_NUM_WIDTH-1:0]  inst_num,
    input  logic [INST_TYPE_WIDTH-1:0] inst_type,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    input  logic                       ifu_rsp_valid,
    output logic                       inst_latch_en,
    output logic                       lsu_req_valid,
    input  logic                       lsu_req_ready,
    output logic                       lsu_we,
    input  logic                       lsu_rsp_valid,
    output logic                       mem_r_latch_en,
    output logic                       gpr_w_en,
    output logic                       pc_w_en,
    output logic [INSTRET_WIDTH-1:0]   instret,
    output logic                       halt,
    output logic                       err
);

    seq_state_e state;
    seq_state_e state_nxt;
    inst_cls_e  cls;
    logic       wd_expire;
    logic       wd_inc;
    logic       wd_clr;

    assign cls = classify(inst_num);

    assign wd_inc = (state == SEQ_IF_REQ)  || (state == SEQ_IF_WAIT) ||
                    (state == SEQ_MEM_REQ) || (state == SEQ_MEM_WAIT);
    assign wd_clr = (state_nxt != state);

    seq_wait_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In every wait state the exit condition is tested before the watchdog, so a
    // handshake completing on the last allowed cycle still proceeds normally.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE:     state_nxt = SEQ_IF_REQ;
            SEQ_IF_REQ: begin
                if (ifu_req_ready)  state_nxt = SEQ_IF_WAIT;
                else if (wd_expire) state_nxt = SEQ_ERR;
            end
            SEQ_IF_WAIT: begin
                if (ifu_rsp_valid)  state_nxt = SEQ_EXEC;
                else if (wd_expire) state_nxt = SEQ_ERR;
            end
            SEQ_EXEC: begin
                case (cls)
                    CLS_ALU:             state_nxt = SEQ_WB;
                    CLS_LOAD, CLS_STORE: state_nxt = SEQ_MEM_REQ;
                    CLS_HALT:            state_nxt = SEQ_HALT;
                    default:             state_nxt = SEQ_ERR;
                endcase
            end
            SEQ_MEM_REQ: begin
                if (lsu_req_ready)  state_nxt = SEQ_MEM_WAIT;
                else if (wd_expire) state_nxt = SEQ_ERR;
            end
            SEQ_MEM_WAIT: begin
                if (lsu_rsp_valid)  state_nxt = SEQ_WB;
                else if (wd_expire) state_nxt = SEQ_ERR;
            end
            SEQ_WB:       state_nxt = SEQ_IF_REQ;
            SEQ_HALT:     state_nxt = SEQ_HALT;
            SEQ_ERR:      state_nxt = SEQ_ERR;
            default:      state_nxt = SEQ_ERR;
        endcase
    end

    // The latch pulses are qualified by the response, but only inside their own
    // wait state, so a response arriving early (e.g. alongside ready) is ignored.
    always_comb begin
        ifu_req_valid  = 1'b0;
        inst_latch_en  = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_we         = 1'b0;
        mem_r_latch_en = 1'b0;
        gpr_w_en       = 1'b0;
        pc_w_en        = 1'b0;
        halt           = 1'b0;
        err            = 1'b0;
        case (state)
            SEQ_IF_REQ:   ifu_req_valid = 1'b1;
            SEQ_IF_WAIT:  inst_latch_en = ifu_rsp_valid;
            SEQ_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                lsu_we        = (cls == CLS_STORE);
            end
            SEQ_MEM_WAIT: mem_r_latch_en = lsu_rsp_valid && (cls == CLS_LOAD);
            SEQ_WB: begin
                pc_w_en  = 1'b1;
                gpr_w_en = inst_type inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};
            end
            SEQ_HALT:     halt = 1'b1;
            SEQ_ERR: begin
                halt = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (state == SEQ_WB) begin
            instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl
`timescale 1ns/1ps
module tb_core_seq_ctrl;
    import core_seq_ctrl_pkg::*;

    localparam int TO = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    inst_num = '0;
    logic [2:0]    inst_type = '0;
    logic          ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0, inst_latch_en;
    logic          lsu_req_valid, lsu_req_ready = 1'b0, lsu_we, lsu_rsp_valid = 1'b0;
    logic          mem_r_latch_en, gpr_w_en, pc_w_en, halt, err;
    logic [IW-1:0] instret;

    always #5 clk = ~clk;

    core_seq_ctrl #(.TIMEOUT_CYCLES(TO), .INSTRET_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .inst_num(inst_num), .inst_type(inst_type),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .inst_latch_en(inst_latch_en),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_rsp_valid(lsu_rsp_valid), .mem_r_latch_en(mem_r_latch_en),
        .gpr_w_en(gpr_w_en), .pc_w_en(pc_w_en), .instret(instret), .halt(halt), .err(err)
    );

    typedef struct packed {
        logic [5:0] num;
        logic [2:0] typ;
        logic ifr, ifp, lr, lp;
    } stim_t;

    typedef struct packed {
        logic ifu_req, latch, lsu_req, we, mem_r, gpr, pc, hlt, er;
        logic [IW-1:0] ret;
    } obs_t;

    int vectors = 0;
    int miscompares = 0;
    stim_t stim_q[$];
    obs_t  exp_q[$];
    logic [IW-1:0] m_instret;
    int mark;
    int noise_mode;   // 0: idle inputs low, 1: random, 2: everything tied high

    logic [5:0] run_ops [11] = '{INST_ADD, INST_SUB, INST_ADDI, INST_LUI, INST_AUIPC,
                                 INST_JAL, INST_JALR, INST_BEQ, INST_BNE, INST_LW, INST_SW};

    // ---------------- reference model: per-cycle expected trace ----------------
    function automatic logic nz();
        if (noise_mode == 2) return 1'b1;
        if (noise_mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    function automatic stim_t mk(input logic [5:0] num, input logic [2:0] typ);
        stim_t s;
        s.num = num; s.typ = typ;
        s.ifr = nz(); s.ifp = nz(); s.lr = nz(); s.lp = nz();
        return s;
    endfunction

    function automatic obs_t base();
        obs_t e;
        e = '0;
        e.ret = m_instret;
        return e;
    endfunction

    function automatic void push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endfunction

    function automatic void emit_idle();
        push(mk(INST_ADDI, TYPE_I), base());
    endfunction

    // Core stopped: whatever arrives afterwards changes nothing.
    function automatic void emit_tail(input logic is_err);
        obs_t e;
        e = base(); e.hlt = 1'b1; e.er = is_err;
        for (int k = 0; k < 5; k++) push(mk(6'($urandom), 3'($urandom)), e);
    endfunction

    // One handshake phase: the exit input (sel 0..3 = ifr/ifp/lr/lp) rises after d
    // idle cycles; d < 0 means it never rises and the phase lasts TO cycles.
    function automatic bit emit_phase(input logic [5:0] num, input logic [2:0] typ,
                                      input int sel, input int d, input obs_t e_hold, input obs_t e_exit);
        stim_t s;
        bit fire;
        int n;
        n = (d < 0) ? TO : d + 1;
        for (int k = 0; k < n; k++) begin
            s = mk(num, typ);
            fire = (d >= 0) && (k == d);
            case (sel)
                0: s.ifr = fire;
                1: s.ifp = fire;
                2: s.lr  = fire;
                default: s.lp = fire;
            endcase
            push(s, fire ? e_exit : e_hold);
        end
        return d < 0;
    endfunction

    function automatic void build_inst(input logic [5:0] num, input logic [2:0] typ,
                                       input int d_ifr, input int d_ifp, input int d_lr, input int d_lp);
        obs_t h, x;
        bit known, is_ld, is_st;
        known = num inside {[6'd1:6'd13]};
        is_ld = (num == INST_LW);
        is_st = (num == INST_SH) || (num == INST_SW);
        h = base(); h.ifu_req = 1'b1;
        if (emit_phase(num, typ, 0, d_ifr, h, h)) begin emit_tail(1'b1); return; end
        h = base(); x = h; x.latch = 1'b1;
        if (emit_phase(num, typ, 1, d_ifp, h, x)) begin emit_tail(1'b1); return; end
        push(mk(num, typ), base());
        if (!known) begin emit_tail(1'b1); return; end
        if (num == INST_EBREAK) begin emit_tail(1'b0); return; end
        if (is_ld || is_st) begin
            h = base(); h.lsu_req = 1'b1; h.we = is_st;
            if (emit_phase(num, typ, 2, d_lr, h, h)) begin emit_tail(1'b1); return; end
            h = base(); x = h; x.mem_r = is_ld;
            mark = stim_q.size();
            if (emit_phase(num, typ, 3, d_lp, h, x)) begin emit_tail(1'b1); return; end
        end
        x = base(); x.pc = 1'b1;
        x.gpr = typ inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};
        push(mk(num, typ), x);
        m_instret = m_instret + 1'b1;
    endfunction

    function automatic int rd();
        return int'($urandom_range(0, TO - 1));
    endfunction

    // ---------------- driving ----------------
    task automatic run_vec(input stim_t s, output obs_t o);
        @(negedge clk);
        inst_num = s.num; inst_type = s.typ;
        ifu_req_ready = s.ifr; ifu_rsp_valid = s.ifp;
        lsu_req_ready = s.lr;  lsu_rsp_valid = s.lp;
        #1;
        o.ifu_req = ifu_req_valid; o.latch = inst_latch_en;
        o.lsu_req = lsu_req_valid; o.we = lsu_we & lsu_req_valid;
        o.mem_r = mem_r_latch_en;  o.gpr = gpr_w_en; o.pc = pc_w_en;
        o.hlt = halt; o.er = err;  o.ret = instret;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = 4'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_instret = '0;
        stim_q.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o, e;
        noise_mode = 1;
        do_reset();
        emit_idle();
        run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL reset_idle: got %b want %b", o, e); end
        vectors++;
        if (lsu_we !== 1'b0) begin miscompares++; $display("FAIL reset_lsu_we: got %b want 0", lsu_we); end
    endtask

    task automatic test_addi_tied_high();
        obs_t o, e;
        int c = 0;
        noise_mode = 2;
        do_reset();
        emit_idle();
        build_inst(INST_ADDI, TYPE_I, 0, 0, 0, 0);
        build_inst(INST_ADDI, TYPE_I, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL addi cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
    endtask

    task automatic test_mem_delays();
        obs_t o, e;
        int c = 0;
        noise_mode = 1;
        do_reset();
        emit_idle();
        build_inst(INST_SW, TYPE_S, rd(), rd(), 3, rd());
        build_inst(INST_LW, TYPE_I, rd(), rd(), rd(), 5);
        build_inst(INST_SH, TYPE_S, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL mem cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
    endtask

    task automatic test_branch_ebreak();
        obs_t o, e;
        int c = 0;
        noise_mode = 1;
        do_reset();
        emit_idle();
        build_inst(INST_BEQ, TYPE_B, rd(), rd(), 0, 0);
        build_inst(INST_JAL, TYPE_J, rd(), rd(), 0, 0);
        build_inst(INST_EBREAK, TYPE_I, rd(), rd(), 0, 0);
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL ebreak cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        int c = 0;
        noise_mode = 1;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            emit_idle();
            case (t)
                0: build_inst(INST_ADDI, TYPE_I, 0, -1, 0, 0);
                1: build_inst(INST_ADDI, TYPE_I, TO - 1, TO - 1, 0, 0);
                2: build_inst(INST_SW, TYPE_S, 0, 0, -1, 0);
                3: build_inst(INST_LW, TYPE_I, 1, 1, TO - 1, -1);
                default: build_inst(6'h3f, TYPE_R, 0, 0, 0, 0);
            endcase
            while (stim_q.size() > 0) begin
                run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
                if (o !== e) begin miscompares++; $display("FAIL timeout%0d cyc %0d: got %b want %b", t, c, o, e); end
                c++;
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int c = 0;
        noise_mode = 1;
        do_reset();
        emit_idle();
        build_inst(INST_LW, TYPE_I, 0, 1, 0, -1);
        for (int i = 0; i < mark + 2; i++) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rst_memwait cyc %0d: got %b want %b", i, o, e); end
        end
        do_reset();
        emit_idle();
        build_inst(INST_LUI, TYPE_U, 0, -1, 0, 0);
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rst_err cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
        do_reset();
        emit_idle();
        build_inst(INST_ADD, TYPE_R, rd(), rd(), 0, 0);
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL after_err cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int c = 0;
        noise_mode = 1;
        do_reset();
        emit_idle();
        for (int i = 0; i < 20; i++) begin
            build_inst(run_ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rd(), rd());
        end
        while (stim_q.size() > 0) begin
            run_vec(stim_q.pop_front(), o); e = exp_q.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL b2b cyc %0d: got %b want %b", c, o, e); end
            c++;
        end
    endtask

    initial begin
        test_reset();
        test_addi_tied_high();
        test_mem_delays();
        test_branch_ebreak();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
